// File: rtl/output_port_bank.sv
// output_port_bank: memory-mapped bank of latched output ports with load/set/clear/toggle
// writes, registered readback and per-port change pulses.
// Optional macro PORT_SHADOW_EN: writes and readback act on per-port shadow registers,
// and commit copies all shadows to port_out atomically on one edge.
module output_port_bank #(
    parameter int                NUM_PORTS   = 16,
    parameter int                DATA_W      = 8,
    parameter int                ADDR_W      = 8,
    parameter int                BASE_ADDR   = 240,
    parameter logic [DATA_W-1:0] RESET_VALUE = '0
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        write,
    input  logic                        read,
    input  logic [ADDR_W-1:0]           address,
    input  logic [1:0]                  op,
    input  logic [DATA_W-1:0]           data_in,
    input  logic                        commit,
    output logic [DATA_W-1:0]           data_out,
    output logic                        read_valid,
    output logic [NUM_PORTS*DATA_W-1:0] port_out,
    output logic [NUM_PORTS-1:0]        port_changed
);

    localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int AW1   = ADDR_W + 1;
    localparam logic [AW1-1:0] LO_ADDR = AW1'(BASE_ADDR);
    localparam logic [AW1-1:0] HI_ADDR = AW1'(BASE_ADDR + NUM_PORTS - 1);

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_SET   = 2'b01;
    localparam logic [1:0] OP_CLEAR = 2'b10;

    // The decoded window must fit the address space and the port count must be sane.
    if (NUM_PORTS < 1 || NUM_PORTS > 64) begin : g_bad_ports
        $error("output_port_bank: NUM_PORTS must be 1..64");
    end
    if (BASE_ADDR + NUM_PORTS > (1 << ADDR_W)) begin : g_bad_range
        $error("output_port_bank: BASE_ADDR+NUM_PORTS exceeds the address space");
    end

    logic [DATA_W-1:0]    port_q [NUM_PORTS];
    logic [DATA_W-1:0]    port_d [NUM_PORTS];
    logic [DATA_W-1:0]    src_q  [NUM_PORTS];
    logic [DATA_W-1:0]    data_out_q, data_out_d;
    logic                 read_valid_q;
    logic [NUM_PORTS-1:0] changed_q, changed_d;

    logic [AW1-1:0]    addr_x;
    logic              hit, wr_hit, rd_hit;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] cur, wr_val;

    // Decode is done one bit wider than the bus so the window never wraps past the top.
    assign addr_x = {1'b0, address};
    assign hit    = (addr_x >= LO_ADDR) && (addr_x <= HI_ADDR);
    assign idx    = IDX_W'(address - ADDR_W'(BASE_ADDR));
    assign wr_hit = write && hit;
    assign rd_hit = read && hit;

    // Read-modify-write value of the addressed register for the requested operation.
    always_comb begin
        cur    = src_q[idx];
        wr_val = (op == OP_LOAD)  ? data_in :
                 (op == OP_SET)   ? (cur | data_in) :
                 (op == OP_CLEAR) ? (cur & ~data_in) :
                                    (cur ^ data_in);
    end

`ifdef PORT_SHADOW_EN
    logic [DATA_W-1:0] shadow_q [NUM_PORTS];
    logic [DATA_W-1:0] shadow_d [NUM_PORTS];

    // Writes land in the shadows; commit forwards the shadows' next state so a
    // coinciding write is included in the same atomic update.
    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            shadow_d[i] = (wr_hit && idx == IDX_W'(i)) ? wr_val : shadow_q[i];
            port_d[i]   = commit ? shadow_d[i] : port_q[i];
            src_q[i]    = shadow_q[i];
        end
    end

    // Shadow register bank.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_PORTS; i++) shadow_q[i] <= RESET_VALUE;
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) shadow_q[i] <= shadow_d[i];
        end
    end
`else
    logic commit_unused;
    assign commit_unused = commit;

    // Writes go straight to the output registers.
    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            port_d[i] = (wr_hit && idx == IDX_W'(i)) ? wr_val : port_q[i];
            src_q[i]  = port_q[i];
        end
    end
`endif

    // A port pulses only when its visible value actually differs from the old one.
    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) changed_d[i] = (port_d[i] != port_q[i]);
        data_out_d = rd_hit ? cur : data_out_q;
    end

    // Output port registers, change pulses and registered readback.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_PORTS; i++) port_q[i] <= RESET_VALUE;
            changed_q    <= '0;
            data_out_q   <= '0;
            read_valid_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) port_q[i] <= port_d[i];
            changed_q    <= changed_d;
            data_out_q   <= data_out_d;
            read_valid_q <= rd_hit;
        end
    end

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_flat
        assign port_out[g*DATA_W +: DATA_W] = port_q[g];
    end

    assign data_out     = data_out_q;
    assign read_valid   = read_valid_q;
    assign port_changed = changed_q;

endmodule

// File: tb/tb_output_port_bank.sv
// tb_output_port_bank: directed self-checking bench for output_port_bank (16 x 8-bit at 0xF0).
module tb_output_port_bank;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         write = 1'b0;
    logic         read = 1'b0;
    logic [7:0]   address = 8'h00;
    logic [1:0]   op = 2'b00;
    logic [7:0]   data_in = 8'h00;
    logic         commit = 1'b0;
    logic [7:0]   data_out;
    logic         read_valid;
    logic [127:0] port_out;
    logic [15:0]  port_changed;

    logic [7:0]   expv [16];
    int           vec = 0;
    int           bad = 0;

    output_port_bank dut (
        .clk(clk), .reset(reset), .write(write), .read(read), .address(address),
        .op(op), .data_in(data_in), .commit(commit), .data_out(data_out),
        .read_valid(read_valid), .port_out(port_out), .port_changed(port_changed)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] flat();
        logic [127:0] f;
        for (int i = 0; i < 16; i++) f[i*8 +: 8] = expv[i];
        return f;
    endfunction

    function automatic logic [7:0] pv(input int i);
        return port_out[i*8 +: 8];
    endfunction

    task automatic bus(input logic w, input logic r, input logic [7:0] a,
                       input logic [1:0] o, input logic [7:0] d);
        write = w; read = r; address = a; op = o; data_in = d;
        @(posedge clk); #1;
        write = 1'b0; read = 1'b0;
    endtask

    task automatic test_reset;
        for (int i = 0; i < 16; i++) expv[i] = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        vec++; if (port_out !== flat()) begin bad++; $display("FAIL reset_ports got %h want %h", port_out, flat()); end
        vec++; if (read_valid !== 1'b0) begin bad++; $display("FAIL reset_rv got %b want 0", read_valid); end
        vec++; if (port_changed !== 16'h0) begin bad++; $display("FAIL reset_chg got %h want 0000", port_changed); end
        vec++; if (data_out !== 8'h00) begin bad++; $display("FAIL reset_dout got %h want 00", data_out); end
        #2 reset = 1'b1;
        @(posedge clk); #1;
        bus(1, 0, 8'hF3, 2'b00, 8'hA5); expv[3] = 8'hA5;
        vec++; if (port_out !== flat()) begin bad++; $display("FAIL load_f3 got %h want %h", port_out, flat()); end
        vec++; if (port_changed !== 16'h0008) begin bad++; $display("FAIL load_f3_chg got %h want 0008", port_changed); end
        bus(0, 0, 8'h00, 2'b00, 8'h00);
        vec++; if (port_changed !== 16'h0) begin bad++; $display("FAIL chg_pulse_len got %h want 0000", port_changed); end
    endtask

    task automatic test_ops;
        bus(1, 0, 8'hF5, 2'b00, 8'h0F); expv[5] = 8'h0F;
        vec++; if (port_changed !== 16'h0020) begin bad++; $display("FAIL op_load_chg got %h want 0020", port_changed); end
        bus(1, 0, 8'hF5, 2'b01, 8'hF0);
        vec++; if (pv(5) !== 8'hFF) begin bad++; $display("FAIL op_set got %h want ff", pv(5)); end
        bus(1, 0, 8'hF5, 2'b10, 8'h3C);
        vec++; if (pv(5) !== 8'hC3) begin bad++; $display("FAIL op_clear got %h want c3", pv(5)); end
        bus(1, 0, 8'hF5, 2'b11, 8'hFF); expv[5] = 8'h3C;
        vec++; if (pv(5) !== 8'h3C) begin bad++; $display("FAIL op_toggle got %h want 3c", pv(5)); end
        vec++; if (port_changed !== 16'h0020) begin bad++; $display("FAIL op_toggle_chg got %h want 0020", port_changed); end
        bus(1, 0, 8'hF5, 2'b11, 8'h00);
        vec++; if (port_out !== flat()) begin bad++; $display("FAIL op_toggle0 got %h want %h", port_out, flat()); end
        vec++; if (port_changed !== 16'h0) begin bad++; $display("FAIL op_toggle0_chg got %h want 0000", port_changed); end
        bus(1, 0, 8'hF5, 2'b01, 8'h0C);
        vec++; if (port_changed !== 16'h0) begin bad++; $display("FAIL op_set_same_chg got %h want 0000", port_changed); end
        bus(0, 1, 8'hF5, 2'b00, 8'h00);
        vec++; if (data_out !== 8'h3C || read_valid !== 1'b1) begin bad++; $display("FAIL read_f5 got %h/%b want 3c/1", data_out, read_valid); end
    endtask

    task automatic test_miss;
        bus(1, 0, 8'hEF, 2'b00, 8'h77);
        vec++; if (port_out !== flat() || port_changed !== 16'h0) begin bad++; $display("FAIL miss_ef got %h/%h want %h/0000", port_out, port_changed, flat()); end
        bus(1, 0, 8'h00, 2'b00, 8'h77);
        bus(1, 0, 8'h01, 2'b01, 8'hFF);
        vec++; if (port_out !== flat()) begin bad++; $display("FAIL miss_wrap got %h want %h", port_out, flat()); end
        bus(0, 1, 8'hEF, 2'b00, 8'h00);
        vec++; if (read_valid !== 1'b0 || data_out !== 8'h3C) begin bad++; $display("FAIL miss_read got %b/%h want 0/3c", read_valid, data_out); end
        bus(1, 0, 8'hFF, 2'b00, 8'h99); expv[15] = 8'h99;
        vec++; if (port_out !== flat() || port_changed !== 16'h8000) begin bad++; $display("FAIL top_port got %h/%h want %h/8000", port_out, port_changed, flat()); end
    endtask

    task automatic test_rw_same;
        bus(1, 0, 8'hF0, 2'b00, 8'h11);
        bus(1, 1, 8'hF0, 2'b00, 8'h22); expv[0] = 8'h22;
        vec++; if (data_out !== 8'h11 || read_valid !== 1'b1) begin bad++; $display("FAIL rw_read got %h/%b want 11/1", data_out, read_valid); end
        vec++; if (port_out !== flat() || port_changed !== 16'h0001) begin bad++; $display("FAIL rw_write got %h/%h want %h/0001", port_out, port_changed, flat()); end
    endtask

    task automatic test_back_to_back;
        bus(0, 1, 8'hF3, 2'b00, 8'h00);
        vec++; if (data_out !== 8'hA5 || read_valid !== 1'b1) begin bad++; $display("FAIL b2b_first got %h/%b want a5/1", data_out, read_valid); end
        bus(0, 1, 8'hFF, 2'b00, 8'h00);
        vec++; if (data_out !== 8'h99 || read_valid !== 1'b1) begin bad++; $display("FAIL b2b_second got %h/%b want 99/1", data_out, read_valid); end
        bus(0, 0, 8'h00, 2'b00, 8'h00);
        vec++; if (read_valid !== 1'b0 || data_out !== 8'h99) begin bad++; $display("FAIL b2b_idle got %b/%h want 0/99", read_valid, data_out); end
    endtask

    task automatic test_reset_mid;
        bus(1, 0, 8'hF2, 2'b00, 8'h40); expv[2] = 8'h40;
        vec++; if (pv(2) !== 8'h40) begin bad++; $display("FAIL pre_reset got %h want 40", pv(2)); end
        write = 1'b1; address = 8'hF2; op = 2'b00; data_in = 8'h41;
        #2 reset = 1'b0;
        #1;
        for (int i = 0; i < 16; i++) expv[i] = 8'h00;
        vec++; if (port_out !== flat() || data_out !== 8'h00 || read_valid !== 1'b0 || port_changed !== 16'h0) begin
            bad++; $display("FAIL async_reset got %h/%h/%b/%h want all zero", port_out, data_out, read_valid, port_changed); end
        @(posedge clk); #1;
        write = 1'b0;
        #2 reset = 1'b1;
        @(posedge clk); #1;
        vec++; if (port_out !== flat() || port_changed !== 16'h0) begin bad++; $display("FAIL post_reset got %h/%h want %h/0000", port_out, port_changed, flat()); end
    endtask

    task automatic test_shadow;
        commit = 1'b0;
        bus(1, 0, 8'hF0, 2'b00, 8'h12);
        bus(1, 0, 8'hF1, 2'b00, 8'h34);
        vec++; if (port_out !== flat() || port_changed !== 16'h0) begin bad++; $display("FAIL shadow_frozen got %h/%h want %h/0000", port_out, port_changed, flat()); end
        bus(0, 1, 8'hF0, 2'b00, 8'h00);
        vec++; if (data_out !== 8'h12) begin bad++; $display("FAIL shadow_rd0 got %h want 12", data_out); end
        bus(0, 1, 8'hF1, 2'b00, 8'h00);
        vec++; if (data_out !== 8'h34) begin bad++; $display("FAIL shadow_rd1 got %h want 34", data_out); end
        commit = 1'b1;
        bus(1, 0, 8'hF2, 2'b00, 8'h56);
        expv[0] = 8'h12; expv[1] = 8'h34; expv[2] = 8'h56;
        vec++; if (port_out !== flat() || port_changed !== 16'h0007) begin bad++; $display("FAIL shadow_commit got %h/%h want %h/0007", port_out, port_changed, flat()); end
        bus(0, 0, 8'h00, 2'b00, 8'h00);
        vec++; if (port_changed !== 16'h0) begin bad++; $display("FAIL shadow_recommit_chg got %h want 0000", port_changed); end
    endtask

    initial begin
`ifdef PORT_SHADOW_EN
        commit = 1'b1;
`endif
        test_reset;
        test_ops;
        test_miss;
        test_rw_same;
        test_back_to_back;
        test_reset_mid;
`ifdef PORT_SHADOW_EN
        test_shadow;
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end

endmodule

// File: doc/output_port_bank.md
Name: output_port_bank

Overview:
Parametrised memory-mapped bank of latched output ports. Generalises the fixed 16 x 8-bit output block with the following additions:
- configurable port count, width and base address
- set/clear/toggle write operations
- registered readback
- per-port change pulses
- optional double-buffered (shadow/commit) update
Sits on the CPU data bus alongside RAM and input ports; decodes the top of the address space.

Parameters:
NUM_PORTS, 16, number of output ports (1..64)
DATA_W, 8, width of each port and of the data bus
ADDR_W, 8, address bus width
BASE_ADDR, 240, address of port 0; port i is at BASE_ADDR+i
RESET_VALUE, 0, value of every port register after reset

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
write  in  1  write strobe, sampled at clk rise
read  in  1  read strobe, sampled at clk rise
address  in  ADDR_W  bus address
op  in  2  write operation: 00 load, 01 set bits, 10 clear bits, 11 toggle bits
data_in  in  DATA_W  write data / bit mask
commit  in  1  shadow-to-output transfer (used only with PORT_SHADOW_EN)
data_out  out  DATA_W  registered readback data
read_valid  out  1  one-cycle pulse: data_out holds the value for a read hit
port_out  out  NUM_PORTS*DATA_W  flattened port values; port i at bits [i*DATA_W +: DATA_W]
port_changed  out  NUM_PORTS  one-cycle pulse per port whose port_out value changed

Behaviour:
- Reset (async, active-low, any time including mid-access):
  - all port registers (and shadows) = RESET_VALUE
  - data_out = 0, read_valid = 0, port_changed = 0
  - the access in flight is discarded
- Decode:
  - hit when BASE_ADDR <= address <= BASE_ADDR+NUM_PORTS-1, compared at ADDR_W+1 bits so there is no wrap.
  - BASE_ADDR+NUM_PORTS > 2**ADDR_W is an elaboration error.
  - index = address - BASE_ADDR.
- Write (write=1 and hit), applied at the next clk rise:
  - load: R = data_in
  - set: R = R | data_in
  - clear: R = R & ~data_in
  - toggle: R = R ^ data_in
  - write with a miss: no state change.
- Read (read=1 and hit):
  - next cycle data_out = the register value before any same-cycle write (read-before-write), read_valid = 1.
  - read with a miss: read_valid = 0 next cycle, data_out holds its previous value.
  - read_valid is a single-cycle pulse per read hit; back-to-back reads give consecutive pulses.
- port_changed[i]:
  - asserted for exactly the one cycle in which port_out i first shows a new value differing from its old value.
  - operations that produce an identical value (set of already-set bits, toggle with mask 0, reload of the same value) produce no pulse.
- Latency: write to port_out visible 1 cycle; read strobe to data_out 1 cycle.
- Simultaneous write and read to the same port: read returns the old value; write takes effect normally.
- At most one port is written per cycle.

Optional Feature:
Macro PORT_SHADOW_EN.
- Defined:
  - each port has a shadow register; write ops and readback act on the shadow.
  - commit=1 copies every shadow's next-state value to port_out on the same edge, so a write coinciding with commit is included.
  - port_changed is evaluated on port_out at commit.
  - without commit, port_out is frozen.
  - all ports update atomically on commit.
- Undefined:
  - no shadow registers; writes go straight to port_out.
  - commit is ignored.

Test Plan:
- Reset held low, then released → all 16 port_out = 0x00, read_valid=0, port_changed=0; then load 0xA5 to 0xF3 → port_out[3]=0xA5 one cycle later, port_changed=0x0008 for one cycle.
- port 5 = 0x0F; set 0xF0 → 0xFF; clear 0x3C → 0xC3; toggle 0xFF → 0x3C; toggle 0x00 → 0x3C with no port_changed pulse.
- Write 0x77 to address 0xEF and to 0x100-wrapped values outside the range → no port changes; read 0xEF → read_valid stays 0.
- Port 0 = 0x11; same cycle: read 0xF0 and load 0x22 to 0xF0 → next cycle data_out=0x11 with read_valid=1; port_out[0]=0x22.
- Write port 2 = 0x40, assert reset low mid-write for a non-aligned pulse → port_out[2]=0x00 immediately, data_out=0, no change pulses after release.
- PORT_SHADOW_EN: write 0x12 to 0xF0 and 0x34 to 0xF1 → port_out unchanged and readback 0x12/0x34; then commit together with load 0x56 to 0xF2 → ports 0..2 = 0x12/0x34/0x56 on one edge, port_changed=0x0007.
